// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer: streams host instruction words into the cpu instruction
// memory through its initialize port while holding the cpu in reset. It then
// releases initialize and cpu reset together after a fixed hold period.
module imem_boot_sequencer #(
    parameter int MAX_WORDS = 64,  // instruction-memory depth in words, power of 2, >= 2
    parameter int HOLD_CYC  = 4    // cycles initialize/cpu_rst stay high after the final write, >= 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [31:0]                  in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         initialize,
    output logic [31:0]                  instruction_initialize_address,
    output logic [31:0]                  instruction_initialize_data,
    output logic                         cpu_rst,
    output logic                         busy,
    output logic [$clog2(MAX_WORDS):0]   word_count,
    output logic                         overflow
);

    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            init_q, init_d;
    logic            xfer;

    // Readiness depends on state only, so the host never sees a combinational path from valid.
    assign in_ready = (state_q == S_LOAD);
    assign xfer     = in_ready & in_valid;

    // Next-state, write-port and bookkeeping logic for the load sequence.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case leaves a latch.
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_d  = '0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    data_d  = in_data;
                    addr_d  = {30'(count_q), 2'b00};
                    count_d = count_q + CW'(1);
                    if (in_last) begin
                        state_d = S_HOLD;
                    end else if (count_q == CW'(MAX_WORDS - 1)) begin
                        // Memory is full and the host has not ended the program.
                        ovf_d   = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HW'(HOLD_CYC - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // One registered bit drives both initialize and cpu_rst, so they cannot differ.
        init_d = (state_d != S_RUN);
    end

    // State and output registers. Reset is synchronous and aborts any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= '0;
            init_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            init_q  <= init_d;
        end
    end

    assign initialize                     = init_q;
    assign cpu_rst                        = init_q;
    assign instruction_initialize_address = addr_q;
    assign instruction_initialize_data    = data_q;
    assign busy                           = (state_q == S_LOAD) || (state_q == S_HOLD);
    assign word_count                     = count_q;
    assign overflow                       = ovf_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench for imem_boot_sequencer. The driver pushes each expected
// (address, data) write onto a scoreboard when it offers the word. The monitor
// pops an entry whenever the cpu write port changes.
module tb_imem_boot_sequencer;

    localparam int MAX_WORDS = 4;
    localparam int HOLD_CYC  = 4;
    localparam int CW        = $clog2(MAX_WORDS) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_last;
    logic          in_ready;
    logic          initialize;
    logic [31:0]   ii_addr;
    logic [31:0]   ii_data;
    logic          cpu_rst;
    logic          busy;
    logic [CW-1:0] word_count;
    logic          overflow;

    int            n_vec = 0;
    int            n_err = 0;
    logic [63:0]   sb[$];
    logic [31:0]   exp_addr;
    logic [31:0]   prev_a, prev_d;

    imem_boot_sequencer #(.MAX_WORDS(MAX_WORDS), .HOLD_CYC(HOLD_CYC)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .in_valid                       (in_valid),
        .in_data                        (in_data),
        .in_last                        (in_last),
        .in_ready                       (in_ready),
        .initialize                     (initialize),
        .instruction_initialize_address (ii_addr),
        .instruction_initialize_data    (ii_data),
        .cpu_rst                        (cpu_rst),
        .busy                           (busy),
        .word_count                     (word_count),
        .overflow                       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: any change on the write port must match the oldest pending expected write.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_a = ii_addr;
            prev_d = ii_data;
        end else if (ii_addr !== prev_a || ii_data !== prev_d) begin
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("write", {ii_addr, ii_data}, sb.pop_front());
            prev_a = ii_addr;
            prev_d = ii_data;
        end
    end

    // Drive one word from a negedge; returns on the next negedge.
    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("ready_in_load", 64'(in_ready), 64'd1);
        sb.push_back({exp_addr, d});
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the first negedge in HOLD. It checks the hold window and the release edge.
    task automatic wait_hold(input int exp_cnt, input logic exp_ovf, input logic poke_start);
        for (int i = 0; i < HOLD_CYC; i++) begin
            start = poke_start && (i == 0);
            check("hold_init", 64'(initialize), 64'd1);
            check("hold_cpu_rst", 64'(cpu_rst), 64'd1);
            check("hold_busy", 64'(busy), 64'd1);
            check("hold_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        start = 1'b0;
        check("run_init", 64'(initialize), 64'd0);
        check("run_cpu_rst", 64'(cpu_rst), 64'd0);
        check("run_busy", 64'(busy), 64'd0);
        check("run_ready", 64'(in_ready), 64'd0);
        check("run_count", 64'(word_count), 64'(exp_cnt));
        check("run_overflow", 64'(overflow), 64'(exp_ovf));
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_load_entry();
        check("load_init", 64'(initialize), 64'd1);
        check("load_cpu_rst", 64'(cpu_rst), 64'd1);
        check("load_count", 64'(word_count), 64'd0);
        check("load_overflow", 64'(overflow), 64'd0);
        check("load_busy", 64'(busy), 64'd1);
        exp_addr = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        exp_addr = '0;

        // T1: reset held for three cycles.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_init", 64'(initialize), 64'd1);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_addr", 64'(ii_addr), 64'd0);
        check("rst_data", 64'(ii_data), 64'd0);

        // T2: four-word load, valid every cycle, last word hits the depth limit with in_last.
        pulse_start();
        check_load_entry();
        send(32'h0002_0820, 1'b0);
        send(32'h0022_0820, 1'b0);
        send(32'h0022_182A, 1'b0);
        send(32'h0041_182A, 1'b1);
        wait_hold(4, 1'b0, 1'b0);

        // T3: reload with gaps in valid; address and data must hold through the gap.
        pulse_start();
        check_load_entry();
        send(32'hA5A5_0001, 1'b0);
        idle_cycle();
        idle_cycle();
        check("gap_count", 64'(word_count), 64'd1);
        send(32'hA5A5_0002, 1'b1);
        wait_hold(2, 1'b0, 1'b0);

        // T4: overflow with four words and no in_last; a fifth valid is never taken.
        pulse_start();
        check_load_entry();
        send(32'h1111_0000, 1'b0);
        send(32'h2222_0000, 1'b0);
        send(32'h3333_0000, 1'b0);
        send(32'h4444_0000, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        check("ovf_set", 64'(overflow), 64'd1);
        wait_hold(4, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("run_no_accept", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;

        // T5: reload from RUN; start in LOAD and HOLD is ignored.
        pulse_start();
        check_load_entry();
        send(32'h5555_0001, 1'b0);
        pulse_start();
        check("start_in_load_count", 64'(word_count), 64'd1);
        check("start_in_load_busy", 64'(busy), 64'd1);
        send(32'h5555_0002, 1'b1);
        wait_hold(2, 1'b0, 1'b1);

        // T6: reset in the middle of a load after two words.
        pulse_start();
        check_load_entry();
        send(32'h6666_0001, 1'b0);
        send(32'h6666_0002, 1'b0);
        check("pre_rst_count", 64'(word_count), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_count", 64'(word_count), 64'd0);
        check("midrst_addr", 64'(ii_addr), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_init", 64'(initialize), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'h7777_7777;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_no_accept", 64'(word_count), 64'd0);
        @(negedge clk);
        check("sb_final", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
